// File: rtl/tt_mux_pkg.sv
// Shared types and helpers for the user-design mux selection controller.
// Holds the FSM state encoding, default sizing and the one-hot decoder.
package tt_mux_pkg;

  localparam int N_DESIGNS_DEF = 16;
  localparam int AW_DEF        = 4;
  localparam int MAX_DESIGNS   = 256;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    GUARD = 2'd1,
    RESET = 2'd2,
    RUN   = 2'd3
  } state_e;

  // Wide decoder; callers truncate the result to their slot count.
  function automatic logic [MAX_DESIGNS-1:0] onehot(input logic [7:0] idx);
    logic [MAX_DESIGNS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/tt_sync_edge.sv
// Two-flop synchroniser for an asynchronous pad, plus a third flop used to
// form a single-cycle rising-edge pulse.
module tt_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= pad_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;

endmodule

// File: rtl/tt_mux_sel_ctrl.sv
// Selection controller: holds the active slot address and sequences a safe
// switch-over (enable off, guard, held reset, run) toward the tt_um_* slots.
module tt_mux_sel_ctrl
  import tt_mux_pkg::*;
#(
  parameter int N_DESIGNS    = N_DESIGNS_DEF,
  parameter int AW           = AW_DEF,
  parameter int GUARD_CYCLES = 4,
  parameter int RST_CYCLES   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ctrl_sel_inc,
  input  logic                 ctrl_sel_rst,
  input  logic                 ctrl_ena,
  output logic [AW-1:0]        sel_addr,
  output logic [N_DESIGNS-1:0] um_ena,
  output logic                 um_rst_n,
  output logic                 busy
);

  localparam int CNT_MAX = (GUARD_CYCLES > RST_CYCLES) ? GUARD_CYCLES : RST_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);
  localparam logic [AW-1:0] ADDR_LAST  = AW'(N_DESIGNS - 1);

  logic inc_rise, rst_rise, ena_s;
  logic inc_level_unused, rst_level_unused, ena_rise_unused;

  tt_sync_edge u_sync_inc (
    .clk     (clk),
    .rst_n   (rst_n),
    .pad_i   (ctrl_sel_inc),
    .level_o (inc_level_unused),
    .rise_o  (inc_rise)
  );

  tt_sync_edge u_sync_rst (
    .clk     (clk),
    .rst_n   (rst_n),
    .pad_i   (ctrl_sel_rst),
    .level_o (rst_level_unused),
    .rise_o  (rst_rise)
  );

  tt_sync_edge u_sync_ena (
    .clk     (clk),
    .rst_n   (rst_n),
    .pad_i   (ctrl_ena),
    .level_o (ena_s),
    .rise_o  (ena_rise_unused)
  );

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AW-1:0]          sel_addr_q, sel_addr_d;
  logic [N_DESIGNS-1:0]   um_ena_q, um_ena_d;
  logic                   um_rst_n_q, um_rst_n_d;
  logic                   busy_q, busy_d;
  logic                   addr_chg;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    addr_chg   = inc_rise | rst_rise;
    sel_addr_d = sel_addr_q;
    state_d    = state_q;
    cnt_d      = cnt_q;

    if (rst_rise) begin
      sel_addr_d = '0;
    end else if (inc_rise) begin
      sel_addr_d = (sel_addr_q == ADDR_LAST) ? '0 : sel_addr_q + 1'b1;
    end

    if (!ena_s) begin
      state_d = OFF;
      cnt_d   = '0;
    end else if (addr_chg && state_q != OFF) begin
      // A new address restarts the whole sequence, even mid-reset.
      state_d = GUARD;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        OFF: begin
          state_d = GUARD;
          cnt_d   = '0;
        end
        GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            state_d = RESET;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          cnt_d = '0;
        end
        default: begin
          state_d = OFF;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so they land in registers and
    // um_ena drops on the very edge that changes the address.
    um_ena_d   = (state_d == RESET || state_d == RUN)
               ? N_DESIGNS'(onehot(8'(sel_addr_d))) : '0;
    um_rst_n_d = (state_d == RUN);
    busy_d     = (state_d == GUARD || state_d == RESET);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OFF;
      cnt_q      <= '0;
      sel_addr_q <= '0;
      um_ena_q   <= '0;
      um_rst_n_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_addr_q <= sel_addr_d;
      um_ena_q   <= um_ena_d;
      um_rst_n_q <= um_rst_n_d;
      busy_q     <= busy_d;
    end
  end

  assign sel_addr = sel_addr_q;
  assign um_ena   = um_ena_q;
  assign um_rst_n = um_rst_n_q;
  assign busy     = busy_q;

endmodule
